// File: rtl/pr_region_freeze_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pr_region_freeze_ctrl
// Brief   : Per-region freeze/unfreeze responder: drains, freezes and resets
//           one partial-reconfiguration region on conduit request.
// Revision: 1.0 - initial release
// ============================================================================
module pr_region_freeze_ctrl #(
  parameter int IDLE_CYCLES   = 4,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int RESET_CYCLES  = 16,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze_req,
  input  logic       unfreeze_req,
  input  logic       pr_reset_req,
  input  logic       region_idle,
  output logic       freeze_status,
  output logic       unfreeze_status,
  output logic [1:0] illegal_req,
  output logic       region_freeze,
  output logic       region_reset,
  output logic       drain_timeout
);

  localparam logic [2:0] S_RUN        = 3'd0;
  localparam logic [2:0] S_DRAIN      = 3'd1;
  localparam logic [2:0] S_FROZEN     = 3'd2;
  localparam logic [2:0] S_UNFRZ_RST  = 3'd3;
  localparam logic [2:0] S_UNFRZ_DONE = 3'd4;

  localparam logic [CNT_W-1:0] C_IDLE_MAX  = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] C_DRAIN_MAX = CNT_W'(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] C_RST_MAX   = CNT_W'(RESET_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             freeze_req_q;
  logic [1:0]       illegal_q, illegal_d;
  logic             drain_timeout_q, drain_timeout_d;
  logic             region_freeze_q, freeze_status_q, unfreeze_status_q, region_reset_q;

  logic             w_freeze_start;
  logic [CNT_W-1:0] w_cnt_inc, w_idle_inc;

  assign w_freeze_start = freeze_req & ~freeze_req_q;
  assign w_cnt_inc      = (cnt_q  == '1) ? cnt_q  : cnt_q  + 1'b1;
  assign w_idle_inc     = (idle_q == '1) ? idle_q : idle_q + 1'b1;

  // Transitions compare the next counter value so that exactly N cycles are spent.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idle_d          = idle_q;
    drain_timeout_d = drain_timeout_q;
    illegal_d       = illegal_q;
    case (state_q)
      S_RUN: begin
        if (w_freeze_start) begin
          if (!unfreeze_req) begin
            state_d         = S_DRAIN;
            cnt_d           = '0;
            idle_d          = '0;
            drain_timeout_d = 1'b0;
          end else begin
            illegal_d[0] = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        cnt_d  = w_cnt_inc;
        idle_d = region_idle ? w_idle_inc : '0;
        if (idle_d >= C_IDLE_MAX) begin
          state_d = S_FROZEN;
        end else if (cnt_d >= C_DRAIN_MAX) begin
          state_d         = S_FROZEN;
          drain_timeout_d = 1'b1;
        end
      end
      S_FROZEN: begin
        if (unfreeze_req) begin
          if (!freeze_req) begin
            state_d = S_UNFRZ_RST;
            cnt_d   = '0;
          end else begin
            illegal_d[0] = 1'b1;
          end
        end
      end
      S_UNFRZ_RST: begin
        cnt_d = w_cnt_inc;
        if (cnt_d >= C_RST_MAX) begin
          state_d = S_UNFRZ_DONE;
        end
      end
      S_UNFRZ_DONE: begin
        if (!unfreeze_req) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
    if (unfreeze_req && (state_q == S_RUN || state_q == S_DRAIN)) begin
      illegal_d[1] = 1'b1;
    end
    if (!freeze_req && !unfreeze_req) begin
      illegal_d = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_RUN;
      cnt_q             <= '0;
      idle_q            <= '0;
      freeze_req_q      <= 1'b0;
      illegal_q         <= 2'b00;
      drain_timeout_q   <= 1'b0;
      region_freeze_q   <= 1'b0;
      freeze_status_q   <= 1'b0;
      unfreeze_status_q <= 1'b0;
      region_reset_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      idle_q            <= idle_d;
      freeze_req_q      <= freeze_req;
      illegal_q         <= illegal_d;
      drain_timeout_q   <= drain_timeout_d;
      // Moore decodes of the current state, visible one cycle after it.
      region_freeze_q   <= (state_q == S_DRAIN) || (state_q == S_FROZEN) ||
                           (state_q == S_UNFRZ_RST);
      freeze_status_q   <= (state_q == S_FROZEN) || (state_q == S_UNFRZ_RST);
      unfreeze_status_q <= (state_q == S_UNFRZ_DONE);
      region_reset_q    <= pr_reset_req || (state_q == S_UNFRZ_RST);
    end
  end

  assign freeze_status   = freeze_status_q;
  assign unfreeze_status = unfreeze_status_q;
  assign illegal_req     = illegal_q;
  assign region_freeze   = region_freeze_q;
  assign region_reset    = region_reset_q;
  assign drain_timeout   = drain_timeout_q;

endmodule
`default_nettype wire
